hsv_core_mem_response_queue: RTL and testbench

Parametrised, multi-outstanding successor to the single-entry memory response stage. It holds up to DEPTH in-flight load/store descriptors in program order and pairs them with in-order AXI R/B responses. It formats load data (shift plus sign/zero extension, 32- or 64-bit), retires posted memory writes early, and drains stale responses after a flush. It sits between the memory request stage and commit, and emits one registered result per retired op.

---
 rtl/hsv_core_mem_response_queue.sv | 257 +++++++++++++++++++++++++
 tb/tb_hsv_core_mem_response_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_core_mem_response_queue.sv
// Memory response queue: holds up to DEPTH issued load/store descriptors in
// program order, pairs them with in-order AXI R/B responses, formats load data,
// retires posted memory stores early and drains responses orphaned by a flush.
module hsv_core_mem_response_queue #(
  parameter int DATA_W          = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAG_W           = 5
) (
  input  logic                       clk_core,
  input  logic                       rst_core,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_is_write,
  input  logic [1:0]                 in_size,
  input  logic                       in_sign_extend,
  input  logic                       in_misaligned,
  input  logic                       in_is_memory,
  input  logic [31:0]                in_addr,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic                       r_valid,
  output logic                       r_ready,
  input  logic [DATA_W-1:0]          r_data,
  input  logic [1:0]                 r_resp,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [1:0]                 b_resp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TAG_W-1:0]           out_tag,
  output logic [DATA_W-1:0]          out_result,
  output logic                       out_writeback,
  output logic                       out_exception,
  output logic [3:0]                 out_exc_cause,
  output logic [31:0]                out_exc_value,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int OFF_W = $clog2(DATA_W/8);

  // descriptor storage
  logic              r_q_is_write  [DEPTH];
  logic [1:0]        r_q_size      [DEPTH];
  logic              r_q_sext      [DEPTH];
  logic              r_q_mis       [DEPTH];
  logic              r_q_is_memory [DEPTH];
  logic [31:0]       r_q_addr      [DEPTH];
  logic [TAG_W-1:0]  r_q_tag       [DEPTH];

  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [OCC_W-1:0]  r_occ;
  logic [CNT_W-1:0]  r_drain_r, r_drain_w, r_discard_w;

  logic              r_out_valid;
  logic [TAG_W-1:0]  r_out_tag;
  logic [DATA_W-1:0] r_out_result;
  logic              r_out_writeback, r_out_exception;
  logic [3:0]        r_out_exc_cause;
  logic [31:0]       r_out_exc_value;

  logic              w_head_valid, w_head_load, w_head_mstore, w_head_iostore, w_head_mis;
  logic              w_adv, w_busy_r, w_busy_w;
  logic              w_push, w_retire, w_r_hs, w_b_hs;
  logic [31:0]       w_inflight;
  logic [CNT_W-1:0]  w_flush_loads, w_flush_stores;
  logic [CNT_W-1:0]  w_drain_r_n, w_drain_w_n, w_discard_w_n;
  logic [PTR_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_res_result;
  logic              w_res_writeback, w_res_exception;
  logic [3:0]        w_res_exc_cause;
  logic [31:0]       w_res_exc_value;
  logic              w_unused;

  assign w_unused = ^{r_resp[0], b_resp[0]};

  // shift the addressed bytes down, keep 8/16/32/64 bits, extend the rest
  function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] data,
                                                 input logic [OFF_W-1:0]  off,
                                                 input logic [1:0]        size,
                                                 input logic              sext);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] mask;
    logic              top;
    sh = data >> {off, 3'b000};
    case (size)
      2'd0:    begin mask = DATA_W'(8'hFF);         top = sh[7];        end
      2'd1:    begin mask = DATA_W'(16'hFFFF);      top = sh[15];       end
      2'd2:    begin mask = DATA_W'(32'hFFFF_FFFF); top = sh[31];       end
      default: begin mask = '1;                     top = sh[DATA_W-1]; end
    endcase
    return (sh & mask) | ((sext & top) ? ~mask : '0);
  endfunction

  assign w_head_valid   = (r_occ != '0);
  assign w_head_mis     = w_head_valid & r_q_mis[r_rd_ptr];
  assign w_head_load    = w_head_valid & ~r_q_mis[r_rd_ptr] & ~r_q_is_write[r_rd_ptr];
  assign w_head_mstore  = w_head_valid & ~r_q_mis[r_rd_ptr] & r_q_is_write[r_rd_ptr] & r_q_is_memory[r_rd_ptr];
  assign w_head_iostore = w_head_valid & ~r_q_mis[r_rd_ptr] & r_q_is_write[r_rd_ptr] & ~r_q_is_memory[r_rd_ptr];

  assign w_adv    = ~r_out_valid | out_ready;
  assign w_busy_r = (r_drain_r != '0);
  assign w_busy_w = (r_drain_w != '0) | (r_discard_w != '0);

  // The head never handshakes in a flush cycle, so its response is still
  // outstanding and is counted into the drain along with the rest of the queue.
  assign r_ready = ~rst_core & (w_busy_r | (w_head_load & w_adv & ~flush));
  assign b_ready = ~rst_core & (w_busy_w | (w_head_iostore & w_adv & ~flush));
  assign w_r_hs  = r_valid & r_ready;
  assign w_b_hs  = b_valid & b_ready;

  assign w_inflight = 32'(r_occ) + 32'(r_drain_r) + 32'(r_drain_w) + 32'(r_discard_w);
  assign in_ready   = ~rst_core & (r_occ < OCC_W'(DEPTH)) & (w_inflight < 32'(MAX_OUTSTANDING));
  assign w_push     = in_valid & in_ready & ~flush;

  assign w_retire = ~rst_core & ~flush & w_adv &
                    (w_head_mis | w_head_mstore |
                     (w_head_load & ~w_busy_r & r_valid) |
                     (w_head_iostore & ~w_busy_w & b_valid));

  // count issued loads and stores still queued, for the flush drain
  always_comb begin
    w_flush_loads  = '0;
    w_flush_stores = '0;
    w_idx          = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if ((OCC_W'(k) < r_occ) && !r_q_mis[w_idx]) begin
        if (r_q_is_write[w_idx]) w_flush_stores = w_flush_stores + CNT_W'(1);
        else                     w_flush_loads  = w_flush_loads  + CNT_W'(1);
      end
    end
  end

  // next values of the drain/discard counters; inc and dec in one cycle cancel
  always_comb begin
    w_drain_r_n   = r_drain_r;
    w_drain_w_n   = r_drain_w;
    w_discard_w_n = r_discard_w;
    if (w_r_hs && w_busy_r) w_drain_r_n = w_drain_r_n - CNT_W'(1);
    if (w_b_hs && (r_drain_w != '0)) w_drain_w_n = w_drain_w_n - CNT_W'(1);
    else if (w_b_hs && (r_discard_w != '0)) w_discard_w_n = w_discard_w_n - CNT_W'(1);
    if (w_retire && w_head_mstore) w_discard_w_n = w_discard_w_n + CNT_W'(1);
    if (flush) begin
      w_drain_r_n = w_drain_r_n + w_flush_loads;
      w_drain_w_n = w_drain_w_n + w_flush_stores;
    end
  end

  // result of the head op if it retires this cycle
  always_comb begin
    w_res_result    = '0;
    w_res_writeback = 1'b0;
    w_res_exception = 1'b0;
    w_res_exc_cause = 4'd0;
    w_res_exc_value = 32'd0;
    if (w_head_mis) begin
      w_res_exception = 1'b1;
      w_res_exc_cause = r_q_is_write[r_rd_ptr] ? 4'd6 : 4'd4;
      w_res_exc_value = r_q_addr[r_rd_ptr];
    end else if (w_head_load) begin
      if (r_resp[1]) begin
        w_res_exception = 1'b1;
        w_res_exc_cause = 4'd5;
        w_res_exc_value = r_q_addr[r_rd_ptr];
      end else begin
        w_res_result    = fmt_load(r_data, r_q_addr[r_rd_ptr][OFF_W-1:0],
                                   r_q_size[r_rd_ptr], r_q_sext[r_rd_ptr]);
        w_res_writeback = 1'b1;
      end
    end else if (w_head_iostore && b_resp[1]) begin
      w_res_exception = 1'b1;
      w_res_exc_cause = 4'd7;
      w_res_exc_value = r_q_addr[r_rd_ptr];
    end
  end

  // descriptor storage write on push
  always_ff @(posedge clk_core) begin
    if (w_push) begin
      r_q_is_write[r_wr_ptr]  <= in_is_write;
      r_q_size[r_wr_ptr]      <= in_size;
      r_q_sext[r_wr_ptr]      <= in_sign_extend;
      r_q_mis[r_wr_ptr]       <= in_misaligned;
      r_q_is_memory[r_wr_ptr] <= in_is_memory;
      r_q_addr[r_wr_ptr]      <= in_addr;
      r_q_tag[r_wr_ptr]       <= in_tag;
    end
  end

  // pointers, occupancy and drain counters
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_occ       <= '0;
      r_drain_r   <= '0;
      r_drain_w   <= '0;
      r_discard_w <= '0;
    end else begin
      r_drain_r   <= w_drain_r_n;
      r_drain_w   <= w_drain_w_n;
      r_discard_w <= w_discard_w_n;
      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_occ    <= '0;
      end else begin
        if (w_push)   r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_retire) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_retire})
          2'b10:   r_occ <= r_occ + OCC_W'(1);
          2'b01:   r_occ <= r_occ - OCC_W'(1);
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

  // registered result stage
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_out_valid     <= 1'b0;
      r_out_tag       <= '0;
      r_out_result    <= '0;
      r_out_writeback <= 1'b0;
      r_out_exception <= 1'b0;
      r_out_exc_cause <= 4'd0;
      r_out_exc_value <= 32'd0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_retire) begin
      r_out_valid     <= 1'b1;
      r_out_tag       <= r_q_tag[r_rd_ptr];
      r_out_result    <= w_res_result;
      r_out_writeback <= w_res_writeback;
      r_out_exception <= w_res_exception;
      r_out_exc_cause <= w_res_exc_cause;
      r_out_exc_value <= w_res_exc_value;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_tag       = r_out_tag;
  assign out_result    = r_out_result;
  assign out_writeback = r_out_writeback;
  assign out_exception = r_out_exception;
  assign out_exc_cause = r_out_exc_cause;
  assign out_exc_value = r_out_exc_value;
  assign occupancy     = r_occ;

endmodule

// File: tb/tb_hsv_core_mem_response_queue.sv
// Directed bench for the memory response queue: a 32-bit instance covers the
// queue, ordering, store and flush behaviour; a 64-bit instance covers formatting.
module tb_hsv_core_mem_response_queue;

  logic clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  logic        rst_core;
  logic        flush, in_valid, in_ready, in_is_write, in_sign_extend, in_misaligned, in_is_memory;
  logic [1:0]  in_size;
  logic [31:0] in_addr;
  logic [4:0]  in_tag;
  logic        r_valid, r_ready, b_valid, b_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp, b_resp;
  logic        out_valid, out_ready, out_writeback, out_exception;
  logic [4:0]  out_tag;
  logic [31:0] out_result, out_exc_value;
  logic [3:0]  out_exc_cause;
  logic [2:0]  occupancy;

  logic        d_flush, d_in_valid, d_in_ready, d_in_is_write, d_in_sign_extend, d_in_misaligned, d_in_is_memory;
  logic [1:0]  d_in_size;
  logic [31:0] d_in_addr;
  logic [4:0]  d_in_tag;
  logic        d_r_valid, d_r_ready, d_b_valid, d_b_ready;
  logic [63:0] d_r_data;
  logic [1:0]  d_r_resp, d_b_resp;
  logic        d_out_valid, d_out_ready, d_out_writeback, d_out_exception;
  logic [4:0]  d_out_tag;
  logic [63:0] d_out_result;
  logic [31:0] d_out_exc_value;
  logic [3:0]  d_out_exc_cause;
  logic [2:0]  d_occupancy;

  hsv_core_mem_response_queue #(.DATA_W(32), .DEPTH(4), .MAX_OUTSTANDING(8), .TAG_W(5)) dut (
    .clk_core(clk_core), .rst_core(rst_core), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_write(in_is_write), .in_size(in_size),
    .in_sign_extend(in_sign_extend), .in_misaligned(in_misaligned), .in_is_memory(in_is_memory),
    .in_addr(in_addr), .in_tag(in_tag),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_result(out_result),
    .out_writeback(out_writeback), .out_exception(out_exception),
    .out_exc_cause(out_exc_cause), .out_exc_value(out_exc_value), .occupancy(occupancy));

  hsv_core_mem_response_queue #(.DATA_W(64), .DEPTH(4), .MAX_OUTSTANDING(8), .TAG_W(5)) dut64 (
    .clk_core(clk_core), .rst_core(rst_core), .flush(d_flush),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_is_write(d_in_is_write), .in_size(d_in_size),
    .in_sign_extend(d_in_sign_extend), .in_misaligned(d_in_misaligned), .in_is_memory(d_in_is_memory),
    .in_addr(d_in_addr), .in_tag(d_in_tag),
    .r_valid(d_r_valid), .r_ready(d_r_ready), .r_data(d_r_data), .r_resp(d_r_resp),
    .b_valid(d_b_valid), .b_ready(d_b_ready), .b_resp(d_b_resp),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_tag(d_out_tag), .out_result(d_out_result),
    .out_writeback(d_out_writeback), .out_exception(d_out_exception),
    .out_exc_cause(d_out_exc_cause), .out_exc_value(d_out_exc_value), .occupancy(d_occupancy));

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic push(input logic wr, input logic [1:0] sz, input logic se, input logic mis,
                      input logic mem, input logic [31:0] a, input logic [4:0] t);
    in_is_write = wr; in_size = sz; in_sign_extend = se; in_misaligned = mis;
    in_is_memory = mem; in_addr = a; in_tag = t; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // 64-bit formatting vectors: addr, size, sign, r_data, expected result
  logic [31:0] v_addr [4] = '{32'h4, 32'h4, 32'h0, 32'h7};
  logic [1:0]  v_size [4] = '{2'd2, 2'd2, 2'd3, 2'd0};
  logic        v_sext [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [63:0] v_data [4] = '{64'hF000_0000_0000_0000, 64'hF000_0000_0000_0000,
                              64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0000};
  logic [63:0] v_exp  [4] = '{64'h0000_0000_F000_0000, 64'hFFFF_FFFF_F000_0000,
                              64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FF80};

  initial begin
    rst_core = 1'b1; flush = 1'b0; in_valid = 1'b0; in_is_write = 1'b0; in_size = 2'd0;
    in_sign_extend = 1'b0; in_misaligned = 1'b0; in_is_memory = 1'b1; in_addr = 32'd0; in_tag = 5'd0;
    r_valid = 1'b0; r_data = 32'd0; r_resp = 2'd0; b_valid = 1'b0; b_resp = 2'd0; out_ready = 1'b1;
    d_flush = 1'b0; d_in_valid = 1'b0; d_in_is_write = 1'b0; d_in_size = 2'd0; d_in_sign_extend = 1'b0;
    d_in_misaligned = 1'b0; d_in_is_memory = 1'b1; d_in_addr = 32'd0; d_in_tag = 5'd0;
    d_r_valid = 1'b0; d_r_data = 64'd0; d_r_resp = 2'd0; d_b_valid = 1'b0; d_b_resp = 2'd0; d_out_ready = 1'b1;

    // reset
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_r_ready", 64'(r_ready), 0);
    chk("rst_b_ready", 64'(b_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_occ", 64'(occupancy), 0);
    rst_core = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 1);

    // signed byte load at 0x1003
    push(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 32'h1003, 5'd1);
    chk("lb_occ", 64'(occupancy), 1);
    r_valid = 1'b1; r_data = 32'h8000_0000;
    tick();
    r_valid = 1'b0;
    chk("lb_valid", 64'(out_valid), 1);
    chk("lb_result", 64'(out_result), 'hFFFF_FF80);
    chk("lb_wb", 64'(out_writeback), 1);
    chk("lb_tag", 64'(out_tag), 1);
    tick();
    chk("lb_drop_valid", 64'(out_valid), 0);

    // 64-bit formatting
    for (int i = 0; i < 4; i++) begin
      d_in_is_write = 1'b0; d_in_misaligned = 1'b0; d_in_addr = v_addr[i];
      d_in_size = v_size[i]; d_in_sign_extend = v_sext[i]; d_in_tag = 5'(i + 2);
      d_in_valid = 1'b1;
      tick();
      d_in_valid = 1'b0; d_r_valid = 1'b1; d_r_data = v_data[i];
      tick();
      d_r_valid = 1'b0;
      chk("fmt64_valid", 64'(d_out_valid), 1);
      chk("fmt64_result", d_out_result, v_exp[i]);
      chk("fmt64_tag", 64'(d_out_tag), 64'(i + 2));
    end

    // fill the queue, then stall the result port
    for (int i = 0; i < 4; i++) push(1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 5'(i));
    #1;
    chk("full_occ", 64'(occupancy), 4);
    chk("full_in_ready", 64'(in_ready), 0);
    out_ready = 1'b0;
    r_valid = 1'b1; r_data = 32'h1111_1111;
    #1;
    chk("full_r_ready0", 64'(r_ready), 1);
    tick();
    chk("ord_tag0", 64'(out_tag), 0);
    chk("ord_res0", 64'(out_result), 'h1111_1111);
    r_data = 32'h2222_2222;
    #1;
    chk("stall_r_ready", 64'(r_ready), 0);
    tick();
    chk("stall_tag", 64'(out_tag), 0);
    chk("stall_occ", 64'(occupancy), 3);
    chk("stall_in_ready", 64'(in_ready), 1);
    out_ready = 1'b1;
    #1;
    chk("unstall_r_ready", 64'(r_ready), 1);
    tick();
    chk("ord_tag1", 64'(out_tag), 1);
    chk("ord_res1", 64'(out_result), 'h2222_2222);
    r_data = 32'h3333_3333;
    tick();
    chk("ord_tag2", 64'(out_tag), 2);
    chk("ord_res2", 64'(out_result), 'h3333_3333);
    r_data = 32'h4444_4444;
    tick();
    chk("ord_tag3", 64'(out_tag), 3);
    chk("ord_res3", 64'(out_result), 'h4444_4444);
    chk("ord_occ", 64'(occupancy), 0);
    r_valid = 1'b0;
    tick();
    chk("ord_idle", 64'(out_valid), 0);

    // memory store posts, I/O store waits for its own B
    push(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h2000, 5'd4);
    push(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h3000, 5'd5);
    chk("mst_valid", 64'(out_valid), 1);
    chk("mst_tag", 64'(out_tag), 4);
    chk("mst_exc", 64'(out_exception), 0);
    chk("mst_wb", 64'(out_writeback), 0);
    b_valid = 1'b1; b_resp = 2'd0;
    #1;
    chk("discard_b_ready", 64'(b_ready), 1);
    tick();
    chk("discard_no_out", 64'(out_valid), 0);
    chk("discard_occ", 64'(occupancy), 1);
    b_resp = 2'd2;
    tick();
    b_valid = 1'b0; b_resp = 2'd0;
    chk("io_valid", 64'(out_valid), 1);
    chk("io_tag", 64'(out_tag), 5);
    chk("io_exc", 64'(out_exception), 1);
    chk("io_cause", 64'(out_exc_cause), 7);
    chk("io_value", 64'(out_exc_value), 'h3000);
    tick();

    // flush with three loads queued; the concurrent push is dropped
    for (int i = 1; i <= 3; i++) push(1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 32'h40, 5'(i));
    flush = 1'b1;
    in_valid = 1'b1; in_tag = 5'd7;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occ", 64'(occupancy), 0);
    chk("flush_out_valid", 64'(out_valid), 0);
    push(1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 32'h0, 5'd9);
    for (int i = 0; i < 4; i++) begin
      r_valid = 1'b1; r_data = 32'hCAFE_0000 + 32'(i);
      #1;
      chk("drain_r_ready", 64'(r_ready), 1);
      tick();
      if (i < 3) chk("drain_no_out", 64'(out_valid), 0);
    end
    r_valid = 1'b0;
    chk("post_flush_valid", 64'(out_valid), 1);
    chk("post_flush_tag", 64'(out_tag), 9);
    chk("post_flush_res", 64'(out_result), 'hCAFE_0003);
    tick();

    // misaligned half store
    push(1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 32'h1001, 5'd6);
    #1;
    chk("mis_st_b_ready", 64'(b_ready), 0);
    tick();
    chk("mis_st_valid", 64'(out_valid), 1);
    chk("mis_st_exc", 64'(out_exception), 1);
    chk("mis_st_cause", 64'(out_exc_cause), 6);
    chk("mis_st_value", 64'(out_exc_value), 'h1001);
    chk("mis_st_wb", 64'(out_writeback), 0);
    tick();

    // misaligned load, then load with error response
    push(1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 32'h22, 5'd11);
    #1;
    chk("mis_ld_r_ready", 64'(r_ready), 0);
    tick();
    chk("mis_ld_cause", 64'(out_exc_cause), 4);
    chk("mis_ld_value", 64'(out_exc_value), 'h22);
    push(1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 32'h10, 5'd10);
    r_valid = 1'b1; r_resp = 2'd2; r_data = 32'hDEAD_BEEF;
    tick();
    r_valid = 1'b0; r_resp = 2'd0;
    chk("ld_err_exc", 64'(out_exception), 1);
    chk("ld_err_cause", 64'(out_exc_cause), 5);
    chk("ld_err_result", 64'(out_result), 0);
    chk("ld_err_wb", 64'(out_writeback), 0);
    tick();

    // reset mid-operation
    push(1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 32'h80, 5'd12);
    push(1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 32'h84, 5'd13);
    rst_core = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 0);
    tick();
    chk("midrst_occ", 64'(occupancy), 0);
    chk("midrst_out_valid", 64'(out_valid), 0);
    rst_core = 1'b0;
    #1;
    chk("midrst_after_in_ready", 64'(in_ready), 1);
    chk("midrst_after_r_ready", 64'(r_ready), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
